// File: rtl/round_timer_ctrl.sv
// Round sequencer for the math game: drives the shared prescaler, counts down
// the seconds of each question, and tracks round number and time-bonus score.
module round_timer_ctrl #(
    parameter int ROUND_SECS    = 30,
    parameter int TICKS_PER_SEC = 100,
    parameter int NUM_ROUNDS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       answer_valid,
    input  logic       answer_correct,
    input  logic       tick,
    output logic       presc_en,
    output logic       presc_rst_n,
    output logic [6:0] seconds_left,
    output logic [3:0] round_num,
    output logic [7:0] score,
    output logic       round_done,
    output logic       last_correct,
    output logic       timed_out,
    output logic       game_over
);

    localparam int              SW      = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [SW-1:0]   SUB_MAX = SW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]      SECS    = 7'(ROUND_SECS);
    localparam logic [3:0]      LAST_RN = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {IDLE, RUN, PAUSED, RESULT, OVER} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [6:0]    seconds_left_q, seconds_left_d;
    logic [3:0]    round_num_q, round_num_d;
    logic [7:0]    score_q, score_d;
    logic          last_correct_q, last_correct_d;
    logic          timed_out_q, timed_out_d;
    logic          presc_en_q, presc_en_d;
    logic          presc_rst_n_q, presc_rst_n_d;
    logic          round_done_q, round_done_d;
    logic          game_over_q, game_over_d;
    logic [8:0]    score_sum;

    always_comb begin
        state_d        = state_q;
        sub_d          = sub_q;
        seconds_left_d = seconds_left_q;
        round_num_d    = round_num_q;
        score_d        = score_q;
        last_correct_d = last_correct_q;
        timed_out_d    = timed_out_q;
        score_sum      = {1'b0, score_q} + {2'b00, seconds_left_q};

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d        = RUN;
                    round_num_d    = 4'd1;
                    score_d        = 8'd0;
                    seconds_left_d = SECS;
                    sub_d          = '0;
                    last_correct_d = 1'b0;
                    timed_out_d    = 1'b0;
                end
            end
            RUN: begin
                if (answer_valid) begin
                    state_d        = RESULT;
                    last_correct_d = answer_correct;
                    timed_out_d    = 1'b0;
                    if (answer_correct) begin
                        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                    end
                end else begin
                    if (pause) begin
                        state_d = PAUSED;
                    end
                    // The tick is still counted on the cycle pause is taken; a timeout wins over pause.
                    if (tick) begin
                        if (sub_q == SUB_MAX) begin
                            sub_d          = '0;
                            seconds_left_d = seconds_left_q - 7'd1;
                            if (seconds_left_q == 7'd1) begin
                                state_d        = RESULT;
                                last_correct_d = 1'b0;
                                timed_out_d    = 1'b1;
                            end
                        end else begin
                            sub_d = sub_q + SW'(1);
                        end
                    end
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = RUN;
                end
            end
            RESULT: begin
                if (round_num_q == LAST_RN) begin
                    state_d = OVER;
                end else begin
                    state_d        = RUN;
                    round_num_d    = round_num_q + 4'd1;
                    seconds_left_d = SECS;
                    sub_d          = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        presc_en_d    = (state_d == RUN);
        presc_rst_n_d = (state_d == RUN) || (state_d == PAUSED);
        round_done_d  = (state_d == RESULT);
        game_over_d   = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sub_q          <= '0;
            seconds_left_q <= 7'd0;
            round_num_q    <= 4'd0;
            score_q        <= 8'd0;
            last_correct_q <= 1'b0;
            timed_out_q    <= 1'b0;
            presc_en_q     <= 1'b0;
            presc_rst_n_q  <= 1'b0;
            round_done_q   <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sub_q          <= sub_d;
            seconds_left_q <= seconds_left_d;
            round_num_q    <= round_num_d;
            score_q        <= score_d;
            last_correct_q <= last_correct_d;
            timed_out_q    <= timed_out_d;
            presc_en_q     <= presc_en_d;
            presc_rst_n_q  <= presc_rst_n_d;
            round_done_q   <= round_done_d;
            game_over_q    <= game_over_d;
        end
    end

    assign presc_en     = presc_en_q;
    assign presc_rst_n  = presc_rst_n_q;
    assign seconds_left = seconds_left_q;
    assign round_num    = round_num_q;
    assign score        = score_q;
    assign round_done   = round_done_q;
    assign last_correct = last_correct_q;
    assign timed_out    = timed_out_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl with ROUND_SECS=3, TICKS_PER_SEC=4, NUM_ROUNDS=2.
module tb_round_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, answer_valid = 1'b0, answer_correct = 1'b0, tick = 1'b0;
    logic       presc_en, presc_rst_n, round_done, last_correct, timed_out, game_over;
    logic [6:0] seconds_left;
    logic [3:0] round_num;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    round_timer_ctrl #(.ROUND_SECS(3), .TICKS_PER_SEC(4), .NUM_ROUNDS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .answer_valid(answer_valid), .answer_correct(answer_correct), .tick(tick),
        .presc_en(presc_en), .presc_rst_n(presc_rst_n), .seconds_left(seconds_left),
        .round_num(round_num), .score(score), .round_done(round_done),
        .last_correct(last_correct), .timed_out(timed_out), .game_over(game_over)
    );

    typedef struct packed {
        logic       en;
        logic       rn;
        logic [6:0] secs;
        logic [3:0] rnd;
        logic [7:0] sc;
        logic       done;
        logic       lc;
        logic       to;
        logic       go;
    } out_t;

    typedef struct {
        logic [5:0] in;   // {rst, start, pause, answer_valid, answer_correct, tick}
        out_t       exp;
    } vec_t;

    localparam logic [5:0] NONE = 6'b000000, TICK = 6'b000001, AC = 6'b000010,
                           AV = 6'b000100, PAUSE = 6'b001000, START = 6'b010000,
                           RST = 6'b100000;

    vec_t vecs[$];
    out_t exp_q[$];

    function automatic out_t o(input logic en, input logic rn, input int s, input int r,
                               input int sc, input logic d, input logic lc,
                               input logic to, input logic go);
        out_t x;
        x.en = en; x.rn = rn; x.secs = 7'(s); x.rnd = 4'(r); x.sc = 8'(sc);
        x.done = d; x.lc = lc; x.to = to; x.go = go;
        return x;
    endfunction

    task automatic add(input logic [5:0] in, input out_t e);
        vec_t v;
        v.in = in;
        v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input logic [5:0] in, input out_t e);
        for (int i = 0; i < n; i++) add(in, e);
    endtask

    function automatic out_t dut_out();
        out_t x;
        x.en = presc_en; x.rn = presc_rst_n; x.secs = seconds_left; x.rnd = round_num;
        x.sc = score; x.done = round_done; x.lc = last_correct; x.to = timed_out;
        x.go = game_over;
        return x;
    endfunction

    task automatic check1(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        out_t idle_o, got, e;
        int   n_done;

        idle_o = o(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset, start, first decrement, then timeout after 12 ticks
        add(RST, idle_o);
        add(NONE, idle_o);
        add(START, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add(TICK, o(1, 1, 2, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 2, 1, 0, 0, 0, 0, 0));
        add(TICK, o(1, 1, 1, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 1, 1, 0, 0, 0, 0, 0));
        add(TICK, o(0, 0, 0, 1, 0, 1, 0, 1, 0));
        add(NONE, o(1, 1, 3, 2, 0, 0, 0, 1, 0));
        // wrong answer ends the game
        add(AV, o(0, 0, 3, 2, 0, 1, 0, 0, 0));
        add(NONE, o(0, 0, 3, 2, 0, 0, 0, 0, 1));
        add(NONE, o(0, 0, 3, 2, 0, 0, 0, 0, 1));
        // new game: correct at 2 s, then correct at 3 s (answer outranks pause/tick)
        add(START, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add(TICK, o(1, 1, 2, 1, 0, 0, 0, 0, 0));
        add(AV | AC, o(0, 0, 2, 1, 2, 1, 1, 0, 0));
        add(NONE, o(1, 1, 3, 2, 2, 0, 1, 0, 0));
        add(AV | AC | PAUSE | TICK, o(0, 0, 3, 2, 5, 1, 1, 0, 0));
        add(START, o(0, 0, 3, 2, 5, 0, 1, 0, 1));
        // restart from OVER; correct answer on the final tick
        add(START, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add(TICK, o(1, 1, 2, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 2, 1, 0, 0, 0, 0, 0));
        add(TICK, o(1, 1, 1, 1, 0, 0, 0, 0, 0));
        add_n(3, TICK, o(1, 1, 1, 1, 0, 0, 0, 0, 0));
        add(TICK | AV | AC, o(0, 0, 1, 1, 1, 1, 1, 0, 0));
        add(NONE, o(1, 1, 3, 2, 1, 0, 1, 0, 0));
        // pause for 20 cycles with two ticks of progress already made
        add_n(2, TICK, o(1, 1, 3, 2, 1, 0, 1, 0, 0));
        add(PAUSE, o(0, 1, 3, 2, 1, 0, 1, 0, 0));
        for (int i = 0; i < 19; i++)
            add(PAUSE | TICK | ((i % 4 == 0) ? (AV | AC) : NONE), o(0, 1, 3, 2, 1, 0, 1, 0, 0));
        add(NONE, o(1, 1, 3, 2, 1, 0, 1, 0, 0));
        add(TICK, o(1, 1, 3, 2, 1, 0, 1, 0, 0));
        add(TICK, o(1, 1, 2, 2, 1, 0, 1, 0, 0));
        // tick on the cycle pause is taken still counts
        add(TICK, o(1, 1, 2, 2, 1, 0, 1, 0, 0));
        add(PAUSE | TICK, o(0, 1, 2, 2, 1, 0, 1, 0, 0));
        add(NONE, o(1, 1, 2, 2, 1, 0, 1, 0, 0));
        add(TICK, o(1, 1, 2, 2, 1, 0, 1, 0, 0));
        add(TICK, o(1, 1, 1, 2, 1, 0, 1, 0, 0));
        // reset while paused in round 2, then a fresh game
        add(PAUSE, o(0, 1, 1, 2, 1, 0, 1, 0, 0));
        add(RST | PAUSE, idle_o);
        add(NONE, idle_o);
        add(START, o(1, 1, 3, 1, 0, 0, 0, 0, 0));
        add(START | TICK, o(1, 1, 3, 1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            {rst, start, pause, answer_valid, answer_correct, tick} = vecs[i].in;
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vec%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                got = dut_out();
                if (got !== e) begin
                    errors++;
                    $display("FAIL vec%0d: got en=%b rn=%b secs=%0d rnd=%0d sc=%0d done=%b lc=%b to=%b go=%b expected en=%b rn=%b secs=%0d rnd=%0d sc=%0d done=%b lc=%b to=%b go=%b",
                             i, got.en, got.rn, got.secs, got.rnd, got.sc, got.done, got.lc, got.to, got.go,
                             e.en, e.rn, e.secs, e.rnd, e.sc, e.done, e.lc, e.to, e.go);
                end
            end
        end

        // One tick already spent in this round: timeout must come on the 11th further tick.
        n_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            {rst, start, pause, answer_valid, answer_correct} = 5'b0;
            tick = 1'b1;
            @(posedge clk);
            #1;
            if (round_done) begin
                n_done = n;
                break;
            end
        end
        check1("timeout_tick_count", n_done, 11);
        check1("timeout_flag", int'(timed_out), 1);
        check1("timeout_secs", int'(seconds_left), 0);
        @(negedge clk);
        tick = 1'b0;
        @(posedge clk);
        #1;
        check1("round_done_width", int'(round_done), 0);
        check1("next_round_num", int'(round_num), 2);
        check1("next_round_rstn", int'(presc_rst_n), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
